rr_channel_arbiter: RTL and testbench
=====================================

// Module: rr_channel_arbiter
// PURPOSE
//  Round-robin arbiter sharing one req/ack source channel (e.g. one async_operator output or producer) among
//  NUM_REQ consumer-side requesters. Acts as consumer toward the source and as producer toward each requester.
//  Forwards one request at a time, captures the returned word and delivers it to the granted requester.
//  Sits between a shared ARF node and several downstream async_operator inputs. Keeps per-requester served counts.
// PARAMETERS
//  NUM_REQ     4   number of requester channels (>=1)
//  DATA_WIDTH  32  data word width
//  ID_WIDTH    2   grant index width; must be >= clog2(NUM_REQ), and 1 when NUM_REQ==1
//  COUNT_WIDTH 32  width of each served counter
// PORTS
//  clk        in   1                      clock, rising edge
//  rst        in   1                      reset, asynchronous, active-low
//  req_in     in   NUM_REQ                level request per requester
//  ack_out    out  NUM_REQ                one-cycle ack pulse per requester; at most one bit high
//  dout       out  DATA_WIDTH             delivered word; valid while ack_out != 0
//  src_req    out  1                      request to shared source
//  src_ack    in   1                      one-cycle ack pulse from source
//  src_din    in   DATA_WIDTH             source data; valid while src_ack=1
//  grant_id   out  ID_WIDTH               index of current/last grant
//  busy       out  1                      1 in any state other than IDLE
//  proto_err  out  1                      sticky; set on src_ack outside REQ state
//  served     out  NUM_REQ*COUNT_WIDTH    packed served counters; requester i at bits [COUNT_WIDTH*(i+1)-1 : COUNT_WIDTH*i]
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ack_out=0, dout=0, src_req=0, grant_id=0, proto_err=0,
//   all served=0, round-robin pointer last=NUM_REQ-1 (so requester 0 wins first).
//   Reset mid-transaction drops it; in-flight data is lost and no ack is issued.
//  All outputs registered. FSM:
//   IDLE: if |req_in -> pick first i with req_in[i]=1, scanning last+1, last+2, ... mod NUM_REQ;
//         grant_id<=i; src_req<=1; ->REQ. Otherwise stay.
//   REQ: hold src_req=1 until src_ack sampled high. On that edge: data_r<=src_din; src_req<=0; ->DELIVER.
//   DELIVER: if req_in[grant_id]=1: ack_out[grant_id]<=1, dout<=data_r, last<=grant_id,
//            served[grant_id]++ (wraps mod 2^COUNT_WIDTH); ->ACK.
//            If the requester has withdrawn req, stay in DELIVER holding data (transaction not cancelled).
//   ACK: ack_out<=0; ->IDLE. IDLE never grants in the same cycle ack_out is high.
//  Latency: req_in seen in IDLE at cycle t -> src_req=1 at t+1; src_ack at cycle a -> ack_out high at a+2
//   (a+1 is the DELIVER cycle), provided req held. Best case: one transfer per 4 cycles plus source latency.
//  src_req drops the cycle after src_ack, so a source checking (req & ~ack) never double-fires.
//  Request changes during REQ/DELIVER/ACK do not affect the grant. The pointer advances only on delivery.
//  src_ack while not in REQ: ignored for data, proto_err<=1 (cleared only by reset).
//  NUM_REQ==1: degenerates to a registered pass-through; the pointer is always 0.
//  Fairness: with all req_in held high, grants cycle 0,1,..,NUM_REQ-1,0,...; the wait for any requester is
//   bounded by NUM_REQ transfers.
// STRUCTURE
//  Shared header arf_defs.vh: FSM state encodings (IDLE=2'd0, REQ=2'd1, DELIVER=2'd2, ACK=2'd3).
//  Sub-module rr_pick (combinational): inputs req vector and last pointer; outputs valid and index of the
//   next requester in round-robin order. Instantiated once; FSM, data register and counters live in the top.
// TESTING
//  1 Reset: hold rst=0 with random req_in/src_ack -> all outputs 0, proto_err=0; release -> IDLE.
//  2 Single requester: req_in=4'b0100, source acks with 0x2A two cycles after src_req ->
//    ack_out=4'b0100, dout=0x2A, served[2]=1, grant_id=2.
//  3 All requesters high, source returns 0,1,2,...: 8 transfers -> grant order 0,1,2,3,0,1,2,3,
//    words delivered in that order, each served=2.
//  4 Withdraw: requester 1 drops req after grant, re-raises it 5 cycles later ->
//    data held, ack_out[1] pulses after re-raise, no other grant meanwhile.
//  5 Spurious src_ack in IDLE -> proto_err=1 sticky, no ack_out, counters unchanged.
//  6 Reset pulse during REQ -> src_req=0 immediately (async), no ack_out; next grant is requester 0.

Source files
------------

// File: rtl/rr_channel_arbiter_pkg.sv
// Shared definitions for the round-robin channel arbiter: FSM state encoding.
package rr_channel_arbiter_pkg;

    // Arbiter transaction phases; encodings are fixed so that debug views and
    // other blocks reading the state agree on the numeric values.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DELIVER = 2'd2,
        ST_ACK     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_channel_arbiter_if.sv
// Handshake bundle of the arbiter: requester-side req/ack/data and the shared
// source-side req/ack/data. The arbiter connects through the slave modport,
// the surrounding logic (requesters plus source) through the master modport.
interface rr_channel_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]    req_in;
    logic [NUM_REQ-1:0]    ack_out;
    logic [DATA_WIDTH-1:0] dout;
    logic                  src_req;
    logic                  src_ack;
    logic [DATA_WIDTH-1:0] src_din;

    modport slave (
        input  req_in, src_ack, src_din,
        output ack_out, dout, src_req
    );

    modport master (
        output req_in, src_ack, src_din,
        input  ack_out, dout, src_req
    );
endinterface

// File: rtl/rr_channel_arbiter_pick.sv
// Combinational round-robin selector: returns the first active requester
// found scanning last+1, last+2, ... with wrap-around.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic                valid,
    output logic [ID_WIDTH-1:0] idx
);
    // Lowest requester above the pointer wins; if none, lowest at or below it.
    // Loops run downward so the lowest matching index is the final assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_WIDTH'(i) <= last)) begin
                valid = 1'b1;
                idx   = ID_WIDTH'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_WIDTH'(i) > last)) begin
                valid = 1'b1;
                idx   = ID_WIDTH'(i);
            end
        end
    end
endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter sharing one req/ack source among NUM_REQ requesters.
// One transaction at a time: grant, fetch a word from the source, deliver it
// to the granted requester with a one-cycle ack, then return to idle.
module rr_channel_arbiter
    import rr_channel_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 2,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    rr_channel_arbiter_if.slave            bus,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           busy,
    output logic                           proto_err,
    output logic [NUM_REQ*COUNT_WIDTH-1:0] served
);
    arb_state_t            state_reg;
    logic [ID_WIDTH-1:0]   grant_reg;
    logic [ID_WIDTH-1:0]   last_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic [NUM_REQ-1:0]    ack_reg;
    logic                  src_req_reg;
    logic                  proto_err_reg;

    logic                  pick_valid;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic [NUM_REQ-1:0]    req_hit;
    logic                  granted_req;
    logic                  deliver_now;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req   (bus.req_in),
        .last  (last_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Per-requester decode of the current grant and its served counter.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [COUNT_WIDTH-1:0] cnt_reg;

        assign grant_onehot[gi] = (grant_reg == ID_WIDTH'(gi));
        assign req_hit[gi]      = grant_onehot[gi] & bus.req_in[gi];

        // Count completed deliveries; wraps naturally at 2^COUNT_WIDTH.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_reg <= '0;
            end else if (deliver_now && grant_onehot[gi]) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign served[COUNT_WIDTH*gi +: COUNT_WIDTH] = cnt_reg;
    end

    // Delivery happens only while the granted requester still asks for data.
    assign granted_req = |req_hit;
    assign deliver_now = (state_reg == ST_DELIVER) && granted_req;

    // Transaction FSM with registered handshake outputs and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            last_reg      <= ID_WIDTH'(NUM_REQ - 1);
            data_reg      <= '0;
            dout_reg      <= '0;
            ack_reg       <= '0;
            src_req_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            if (bus.src_ack && (state_reg != ST_REQ)) begin
                proto_err_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_reg   <= pick_idx;
                        src_req_reg <= 1'b1;
                        state_reg   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.src_ack) begin
                        data_reg    <= bus.src_din;
                        src_req_reg <= 1'b0;
                        state_reg   <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    // A withdrawn request parks here with the word held.
                    if (granted_req) begin
                        ack_reg   <= grant_onehot;
                        dout_reg  <= data_reg;
                        last_reg  <= grant_reg;
                        state_reg <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    ack_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_out = ack_reg;
    assign bus.dout    = dout_reg;
    assign bus.src_req = src_req_reg;
    assign grant_id    = grant_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign proto_err   = proto_err_reg;
endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed bench for rr_channel_arbiter: the main block plays requesters and
// the source; a monitor pops a scoreboard of expected deliveries on each ack.
module tb_rr_channel_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int IDW     = 2;
    localparam int CW      = 32;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic                  proto_err;
    logic [NUM_REQ*CW-1:0] served;

    rr_channel_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

    rr_channel_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_WIDTH  (DW),
        .ID_WIDTH    (IDW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .grant_id  (grant_id),
        .busy      (busy),
        .proto_err (proto_err),
        .served    (served)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int ack_seen  = 0;
    int exp_acks  = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    exp_t push_e;
    logic [CW-1:0] model_served [NUM_REQ];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every ack must match the oldest expected delivery.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) model_served[i] = '0;
        end else if (bus.ack_out !== '0) begin
            ack_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 64'(bus.ack_out), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                model_served[mon_e.id] = model_served[mon_e.id] + 1'b1;
                check("ack_onehot", 64'(bus.ack_out), 64'd1 << mon_e.id);
                check("dout", 64'(bus.dout), 64'(mon_e.data));
                check("ack_grant_id", 64'(grant_id), 64'(mon_e.id));
                check("served_cnt", 64'(served[mon_e.id*CW +: CW]), 64'(model_served[mon_e.id]));
                $display("ack id=%0d dout=0x%0h served=%0d", mon_e.id, bus.dout,
                         served[mon_e.id*CW +: CW]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_src_req();
        int n = 0;
        while (bus.src_req !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check("src_req_seen", 64'(bus.src_req), 64'd1);
    endtask

    task automatic expect_delivery(input int id, input logic [DW-1:0] word);
        push_e.id   = id;
        push_e.data = word;
        sb_q.push_back(push_e);
        exp_acks++;
    endtask

    task automatic source_ack(input logic [DW-1:0] word);
        bus.src_ack = 1'b1;
        bus.src_din = word;
        step();
        bus.src_ack = 1'b0;
        bus.src_din = $urandom();
        check("src_req_drop", 64'(bus.src_req), 64'd0);
    endtask

    task automatic serve(input int exp_id, input logic [DW-1:0] word, input int lat);
        wait_src_req();
        check("grant_id", 64'(grant_id), 64'(exp_id));
        expect_delivery(exp_id, word);
        repeat (lat) step();
        source_ack(word);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack_seen < exp_acks && n < 30) begin
            step();
            n++;
        end
        check("ack_arrived", 64'(ack_seen >= exp_acks), 64'd1);
    endtask

    task automatic reset_dut();
        rst         = 1'b0;
        bus.req_in  = '0;
        bus.src_ack = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_in  = '0;
        bus.src_ack = 1'b0;
        bus.src_din = '0;

        // 1: reset held with random inputs
        rst = 1'b0;
        repeat (4) begin
            bus.req_in  = 4'($urandom());
            bus.src_ack = 1'($urandom());
            bus.src_din = $urandom();
            step();
        end
        check("rst_src_req", 64'(bus.src_req), 64'd0);
        check("rst_ack_out", 64'(bus.ack_out), 64'd0);
        check("rst_dout", 64'(bus.dout), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        check("rst_served_lo", served[63:0], 64'd0);
        check("rst_served_hi", served[127:64], 64'd0);
        bus.req_in  = '0;
        bus.src_ack = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("idle_after_rst", 64'(busy), 64'd0);

        // 2: single requester 2, word 0x2A
        bus.req_in = 4'b0100;
        serve(2, 32'h2A, 1);
        wait_ack();
        bus.req_in = '0;
        step();
        step();
        check("single_grant_id", 64'(grant_id), 64'd2);
        check("single_served0", 64'(served[0 +: CW]), 64'd0);

        // 3: all requesters, eight transfers in rotation
        reset_dut();
        bus.req_in = 4'hF;
        for (int k = 0; k < 8; k++) begin
            serve(k % NUM_REQ, DW'(k), k % 3);
            wait_ack();
        end
        bus.req_in = '0;
        repeat (3) step();
        for (int i = 0; i < NUM_REQ; i++) check("rr_served", 64'(served[i*CW +: CW]), 64'd2);
        check("rr_sb_empty", 64'(sb_q.size()), 64'd0);

        // 4: requester 1 withdraws after grant, others request meanwhile
        bus.req_in = 4'b0010;
        wait_src_req();
        check("wd_grant_id", 64'(grant_id), 64'd1);
        bus.req_in = 4'b1101;
        expect_delivery(1, 32'h5555_A0A1);
        step();
        source_ack(32'h5555_A0A1);
        repeat (5) step();
        check("wd_no_ack", 64'(ack_seen), 64'(exp_acks - 1));
        check("wd_busy", 64'(busy), 64'd1);
        check("wd_src_req", 64'(bus.src_req), 64'd0);
        bus.req_in = 4'b0010;
        wait_ack();
        bus.req_in = '0;
        repeat (3) step();

        // 5: spurious source ack in IDLE
        check("sp_idle", 64'(busy), 64'd0);
        check("sp_perr_before", 64'(proto_err), 64'd0);
        bus.src_ack = 1'b1;
        bus.src_din = 32'hDEAD_BEEF;
        step();
        bus.src_ack = 1'b0;
        step();
        check("sp_proto_err", 64'(proto_err), 64'd1);
        repeat (5) step();
        check("sp_sticky", 64'(proto_err), 64'd1);
        check("sp_no_ack", 64'(ack_seen), 64'(exp_acks));
        check("sp_served1", 64'(served[1*CW +: CW]), 64'd3);
        check("sp_served0", 64'(served[0*CW +: CW]), 64'd2);

        // 6: async reset during REQ
        bus.req_in = 4'b1000;
        wait_src_req();
        check("ar_grant_id", 64'(grant_id), 64'd3);
        step();
        rst        = 1'b0;
        bus.req_in = 4'hF;
        #1;
        check("ar_src_req", 64'(bus.src_req), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_proto_err", 64'(proto_err), 64'd0);
        step();
        rst = 1'b1;
        check("ar_no_ack", 64'(ack_seen), 64'(exp_acks));
        serve(0, 32'h00C0_FFEE, 0);
        wait_ack();
        bus.req_in = '0;
        repeat (3) step();
        check("end_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
